// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage hazard scoreboard.
// A small counter per architectural register records how many writes have
// issued from decode but not yet written back. The decode instruction is held
// while any source it reads is pending, or while its destination counter is
// full. Register 0 is hardwired and never tracked.
module decode_hazard_scoreboard #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned TOT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_writes,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  output logic             id_stall,
  output logic             id_issue,
  output logic [31:0]      busy_mask,
  output logic [TOT_W-1:0] outstanding,
  output logic             wb_underflow
);

  localparam int unsigned NumRegs = 32;
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [TOT_W-1:0] TotOne  = TOT_W'(1);

  // Entry 0 exists only so the 5-bit addresses index the array directly;
  // it is held at zero forever.
  logic [CNT_W-1:0] cnt_q [NumRegs];
  logic [CNT_W-1:0] cnt_d [NumRegs];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             underflow_q, underflow_d;

  logic rs_nz, rt_nz, dst_nz, wb_nz;
  logic haz_rs, haz_rt, haz_waw, hazard;
  logic inc, dec, wb_orphan;
  logic [NumRegs-1:0] inc_vec, dec_vec;

  // Hazard detection and issue handshake, purely from registered state.
  // A writeback landing this cycle is deliberately not bypassed.
  always_comb begin
    rs_nz   = (id_rs != 5'd0);
    rt_nz   = (id_rt != 5'd0);
    dst_nz  = (id_dst != 5'd0);
    haz_rs  = id_uses_rs && rs_nz && (cnt_q[id_rs] != '0);
    haz_rt  = id_uses_rt && rt_nz && (cnt_q[id_rt] != '0);
    // Full destination counter would overflow on another issue.
    haz_waw = id_writes && dst_nz && (cnt_q[id_dst] == CntMax);
    hazard  = haz_rs || haz_rt || haz_waw;
    id_issue = id_valid && !id_flush && !hazard && ex_ready && !reset;
    id_stall = id_valid && !id_flush && !id_issue;
  end

  // Classify this cycle's increment and decrement events.
  always_comb begin
    wb_nz     = (wb_addr != 5'd0);
    inc       = id_issue && id_writes && dst_nz;
    dec       = wb_valid && wb_nz && (cnt_q[wb_addr] != '0);
    // Writeback to a register with nothing pending: ignored, but flagged.
    wb_orphan = wb_valid && wb_nz && (cnt_q[wb_addr] == '0);
    inc_vec   = '0;
    dec_vec   = '0;
    if (inc) inc_vec[id_dst] = 1'b1;
    if (dec) dec_vec[wb_addr] = 1'b1;
  end

  // Next-state for the per-register counters, the total and the sticky flag.
  always_comb begin
    for (int unsigned i = 0; i < NumRegs; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int unsigned i = 1; i < NumRegs; i++) begin
      unique case ({inc_vec[i], dec_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntOne;
        2'b01:   cnt_d[i] = cnt_q[i] - CntOne;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    cnt_d[0] = '0;

    // The total only moves when exactly one of the two events occurs,
    // regardless of which registers they hit.
    unique case ({inc, dec})
      2'b10:   tot_d = tot_q + TotOne;
      2'b01:   tot_d = tot_q - TotOne;
      default: tot_d = tot_q;
    endcase

    underflow_d = underflow_q || wb_orphan;
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= '0;
      end
      tot_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tot_q       <= tot_d;
      underflow_q <= underflow_d;
    end
  end

  // Status outputs, derived directly from registered state.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      busy_mask[i] = (cnt_q[i] != '0);
    end
    outstanding  = tot_q;
    wb_underflow = underflow_q;
  end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed, table-driven bench for decode_hazard_scoreboard.
// Each record is one clock cycle: inputs are driven after the falling edge,
// outputs are compared just before the rising edge. Expected busy_mask,
// outstanding and wb_underflow are the state prior to that record's edge.
module tb_decode_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_flush;
  logic [4:0]  id_rs, id_rt, id_dst, wb_addr;
  logic        id_uses_rs, id_uses_rt, id_writes, ex_ready, wb_valid;
  logic        id_stall, id_issue, wb_underflow;
  logic [31:0] busy_mask;
  logic [6:0]  outstanding;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, v, fl;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  dst;
    logic        wr, exr, wbv;
    logic [4:0]  wba;
    logic        est, eis;
    logic [31:0] ebusy;
    logic [6:0]  eout;
    logic        euf;
  } vec_t;

  vec_t vecs[$];

  decode_hazard_scoreboard #(.CNT_W(2), .TOT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_flush     (id_flush),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_writes    (id_writes),
    .ex_ready     (ex_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .id_stall     (id_stall),
    .id_issue     (id_issue),
    .busy_mask    (busy_mask),
    .outstanding  (outstanding),
    .wb_underflow (wb_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, v, fl, input logic [4:0] rs, rt,
                              input logic urs, urt, input logic [4:0] dst,
                              input logic wr, exr, wbv, input logic [4:0] wba,
                              input logic est, eis, input logic [31:0] ebusy,
                              input logic [6:0] eout, input logic euf);
    vec_t r;
    r.rst = rst; r.v = v; r.fl = fl; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.dst = dst; r.wr = wr; r.exr = exr; r.wbv = wbv; r.wba = wba;
    r.est = est; r.eis = eis; r.ebusy = ebusy; r.eout = eout; r.euf = euf;
    return r;
  endfunction

  // Writer to register d with no sources and EX ready.
  function automatic vec_t wr_v(input logic [4:0] d, input logic wbv, input logic [4:0] wba,
                                input logic est, eis, input logic [31:0] ebusy,
                                input logic [6:0] eout, input logic euf);
    return mk(0, 1, 0, 0, 0, 0, 0, d, 1, 1, wbv, wba, est, eis, ebusy, eout, euf);
  endfunction

  // No instruction in decode, optional writeback.
  function automatic vec_t idle_v(input logic rst, wbv, input logic [4:0] wba,
                                  input logic [31:0] ebusy, input logic [6:0] eout,
                                  input logic euf);
    return mk(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, wba, 0, 0, ebusy, eout, euf);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; id_valid = t.v; id_flush = t.fl; id_rs = t.rs; id_rt = t.rt;
    id_uses_rs = t.urs; id_uses_rt = t.urt; id_dst = t.dst; id_writes = t.wr;
    ex_ready = t.exr; wb_valid = t.wbv; wb_addr = t.wba;
  endtask

  initial begin
    vec_t z;
    int   wait_cyc;
    z = idle_v(0, 0, 0, 0, 0, 0);
    drive(z);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Writer to $3, then sub $5,$3,$4 stalls until the writeback has landed.
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 1, 1, 5, 1, 1, 0, 0, 1, 0, 32'h8, 1, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 1, 1, 5, 1, 1, 1, 3, 1, 0, 32'h8, 1, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 1, 1, 5, 1, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    // Writes to $0 and reads of $0 never stall or count.
    vecs.push_back(wr_v(0, 0, 0, 0, 1, 32'h20, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 6, 0, 1, 0, 0, 0, 1, 32'h20, 1, 0));
    vecs.push_back(idle_v(0, 1, 5, 32'h20, 1, 0));
    // Saturate $7, 4th writer stalls on WAW, issues after one writeback.
    vecs.push_back(wr_v(7, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(wr_v(7, 0, 0, 0, 1, 32'h80, 1, 0));
    vecs.push_back(wr_v(7, 0, 0, 0, 1, 32'h80, 2, 0));
    vecs.push_back(wr_v(7, 0, 0, 1, 0, 32'h80, 3, 0));
    vecs.push_back(wr_v(7, 1, 7, 1, 0, 32'h80, 3, 0));
    vecs.push_back(wr_v(7, 0, 0, 0, 1, 32'h80, 2, 0));
    vecs.push_back(idle_v(0, 1, 7, 32'h80, 3, 0));
    vecs.push_back(idle_v(0, 1, 7, 32'h80, 2, 0));
    vecs.push_back(idle_v(0, 1, 7, 32'h80, 1, 0));
    // Simultaneous inc/dec: same register, then different registers.
    vecs.push_back(wr_v(9, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(wr_v(9, 1, 9, 0, 1, 32'h200, 1, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h200, 1, 0));
    vecs.push_back(wr_v(10, 1, 9, 0, 1, 32'h200, 1, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h400, 1, 0));
    // Orphan writeback sets the sticky flag; wb to $0 is ignored; reset clears.
    vecs.push_back(idle_v(0, 1, 12, 32'h400, 1, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h400, 1, 1));
    vecs.push_back(idle_v(0, 1, 0, 32'h400, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 32'h400, 1, 1));
    vecs.push_back(idle_v(0, 0, 0, 32'h0, 0, 0));
    // ex_ready low stalls, flush drops, reset discards cnt[4]=2.
    vecs.push_back(wr_v(4, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(wr_v(4, 0, 0, 0, 1, 32'h10, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 8, 1, 0, 0, 0, 1, 0, 32'h10, 2, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 32'h10, 2, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h10, 2, 0));
    vecs.push_back(idle_v(1, 0, 0, 32'h10, 2, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(idle_v(0, 1, 4, 32'h0, 0, 0));
    vecs.push_back(idle_v(0, 0, 0, 32'h0, 0, 1));
    // Source-use enables gate the read hazards.
    vecs.push_back(wr_v(2, 0, 0, 0, 1, 32'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 1, 0, 0, 1, 0, 0, 1, 0, 32'h4, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      n_vec++;
      chk("id_stall", i, 32'(id_stall), 32'(vecs[i].est));
      chk("id_issue", i, 32'(id_issue), 32'(vecs[i].eis));
      chk("busy_mask", i, busy_mask, vecs[i].ebusy);
      chk("outstanding", i, 32'(outstanding), 32'(vecs[i].eout));
      chk("wb_underflow", i, 32'(wb_underflow), 32'(vecs[i].euf));
    end

    // Stall-to-issue latency: reader of $2 stalls in the writeback cycle and
    // must issue in the very next cycle.
    @(negedge clk);
    z = mk(0, 1, 0, 0, 2, 0, 1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    drive(z);
    #1;
    n_vec++;
    chk("wb_cycle_stall", 100, 32'(id_stall), 32'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    wait_cyc = 0;
    #1;
    while (!id_issue && wait_cyc < 5) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    n_vec++;
    chk("issue_latency", 101, 32'(wait_cyc), 32'd0);
    chk("outstanding_after_wb", 101, 32'(outstanding), 32'd0);

    @(negedge clk);
    drive(idle_v(0, 0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_hazard_scoreboard.md
Name: decode_hazard_scoreboard

Overview:
- Sequences the instruction-decode stage: tracks register-file writes that have been issued from decode but not yet written back.
- Holds the instruction in decode until its source operands are no longer pending, then issues it to EX.
- Sits between fetch/decode and the EX pipeline register; drives the decode stall and issue strobe, and is updated by the writeback port of the register file.

Parameters:
- CNT_W, 2, width of each per-register outstanding-write counter; maximum outstanding writes per register = 2^CNT_W-1.
- TOT_W, 7, width of the total outstanding-write counter; must satisfy 2^TOT_W > 31*(2^CNT_W-1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  decode holds a valid instruction.
- id_flush  input  1  squash the decode instruction this cycle; no issue, no counter increment.
- id_rs  input  5  source register 1 address.
- id_rt  input  5  source register 2 address.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_dst  input  5  destination address, already resolved by the rt/rd select.
- id_writes  input  1  instruction writes id_dst.
- ex_ready  input  1  EX pipeline register can accept an instruction.
- wb_valid  input  1  register-file write occurs at this clock edge.
- wb_addr  input  5  register-file write address.
- id_stall  output  1  hold the fetch/decode registers.
- id_issue  output  1  instruction transfers to EX this cycle.
- busy_mask  output  32  bit i = 1 when cnt[i] != 0; bit 0 is always 0.
- outstanding  output  TOT_W  total pending writes across all registers.
- wb_underflow  output  1  sticky error flag.

Behaviour:
State:
- cnt[1..31]: CNT_W-bit counters.
- tot: TOT_W-bit counter.
- wb_underflow: sticky flag.
- Register 0 is never tracked and is never a hazard.

Reset:
- Synchronous; takes priority over all other inputs.
- All cnt = 0, tot = 0, wb_underflow = 0.
- Outputs after reset: busy_mask = 0, outstanding = 0.
- A reset in the middle of operation discards all pending state. Any later writeback is then counted as an underflow.

Hazard and issue logic (combinational from registered state):
- haz_rs = id_uses_rs & rs!=0 & cnt[rs]!=0.
- haz_rt = id_uses_rt & rt!=0 & cnt[rt]!=0.
- haz_waw = id_writes & dst!=0 & cnt[dst]==MAX. Here MAX = 2^CNT_W-1; this term prevents counter overflow.
- hazard = haz_rs | haz_rt | haz_waw.
- id_issue = id_valid & ~id_flush & ~hazard & ex_ready & ~reset.
- id_stall = id_valid & ~id_flush & ~id_issue.
- When id_valid = 0, both id_stall and id_issue are 0.

Same-cycle writeback is not bypassed:
- A wb to rs in the same cycle does not clear haz_rs.
- The register file write lands at the edge, so issue happens on the following cycle at the earliest.
- Stall-to-issue latency after the last writeback is therefore 1 cycle.

Counter update at each edge:
- inc = id_issue & id_writes & dst!=0.
- dec = wb_valid & wb_addr!=0 & cnt[wb_addr]!=0.
- inc and dec on the same register in the same cycle: that cnt is unchanged and tot is unchanged.
- inc and dec on different registers: each counter updates independently; tot is unchanged.
- inc only: the counter and tot increment. dec only: the counter and tot decrement.
- wb_valid & wb_addr!=0 & cnt[wb_addr]==0: no decrement and wb_underflow is set. It stays set until reset.
- wb to register 0 is ignored.

Outputs:
- busy_mask and outstanding are registered state; they change one edge after the event that causes them.
- There is no state machine beyond the counters. Hazard evaluation is single-cycle, and hazards are re-evaluated every cycle while stalled.

Test Plan:
1. Reset, then issue the writer `add $3` (writes $3, ex_ready=1) -> id_issue=1 and cnt[3]=1. Next cycle `sub $5,$3,$4` -> id_stall=1 and id_issue=0. wb_valid with wb_addr=3 at cycle N -> busy_mask[3]=0 after edge N, and sub issues at cycle N+1.
2. Instruction that writes $0 and a following reader of $0 -> no counter change and no stall; outstanding=0.
3. With CNT_W=2, issue 3 writes to $7 with no writeback -> cnt[7]=3. The 4th writer to $7 stalls (haz_waw). One wb to $7 -> the 4th writer issues the next cycle.
4. cnt[9]=1; in the same cycle, issue a writer to $9 and wb to $9 -> cnt[9] stays 1 and outstanding is unchanged.
5. wb_valid with wb_addr=12 while cnt[12]=0 -> wb_underflow=1 and stays 1. A later reset clears it to 0.
6. Hazard-free instruction with ex_ready=0 -> id_stall=1. Then id_flush=1 -> id_stall=0, id_issue=0 and no counter change. Reset asserted with cnt[4]=2 -> all counters 0 at the next edge.
